// File: rtl/load_store_unit.sv
//==============================================================================
// Module      : load_store_unit
// Description : Initiator side of the single-port memory protocol. Accepts one
//               load or store at a time, drives address / byte-lane mask /
//               replicated write data / command with a one-cycle enable, waits
//               for memory_valid and returns extended load data or a fault.
//               Optional feature macro: LSU_TIMEOUT_EN. When defined, a wait
//               counter aborts a transaction after TIMEOUT_CYCLES cycles.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package controller_pkg;
    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;
endpackage

module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    // execute-stage request
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    // pipeline response
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic        resp_timeout,
    // memory port
    input  logic        memory_ready,
    input  logic        memory_valid,
    input  logic [31:0] read_memory_data,
    output logic [31:0] read_memory_address,
    output logic [31:0] write_memory_address,
    output logic [31:0] write_memory_data,
    output logic [31:0] write_memory_mask,
    output logic        memory_command,
    output logic        memory_enable
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    // latched request
    logic [31:0] addr_reg;
    logic [1:0]  size_reg;
    logic        unsigned_reg;
    logic        write_reg;
    logic [31:0] wdata_reg;
    logic [31:0] mask_reg;
    logic [31:0] rdata_reg;
    logic        misaligned_reg;
    logic        timeout_reg;

    // combinational helpers
    logic        accept;
    logic        req_misaligned;
    logic [31:0] store_data;
    logic [31:0] store_mask;
    logic [31:0] load_shifted;
    logic [31:0] load_data;
    logic        timeout_hit;
    logic        timeout_fire;

    assign accept = (state == IDLE) && req_valid;

    // Decode alignment and build lane-replicated store data and its bit mask.
    // Size 3 falls into the word branch.
    always_comb begin
        req_misaligned = 1'b0;
        store_data     = 32'h0;
        store_mask     = 32'h0;
        case (req_size)
            2'd0: begin
                store_data = {4{req_wdata[7:0]}};
                store_mask = 32'h0000_00FF << {req_address[1:0], 3'b000};
            end
            2'd1: begin
                req_misaligned = req_address[0];
                store_data     = {2{req_wdata[15:0]}};
                store_mask     = 32'h0000_FFFF << {req_address[1], 4'b0000};
            end
            default: begin
                req_misaligned = |req_address[1:0];
                store_data     = req_wdata;
                store_mask     = 32'hFFFF_FFFF;
            end
        endcase
    end

    // Align the returned word to the addressed lane and extend to 32 bits.
    always_comb begin
        load_shifted = read_memory_data >> {addr_reg[1:0], 3'b000};
        case (size_reg)
            2'd0: load_data = unsigned_reg ? {24'h0, load_shifted[7:0]}
                                           : {{24{load_shifted[7]}}, load_shifted[7:0]};
            2'd1: load_data = unsigned_reg ? {16'h0, load_shifted[15:0]}
                                           : {{16{load_shifted[15]}}, load_shifted[15:0]};
            default: load_data = load_shifted;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    logic [31:0] wait_count;

    // Cycles spent in ISSUE/WAIT for the current transaction; zero on entry to ISSUE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_count <= 32'h0;
        end else if (accept) begin
            wait_count <= 32'h0;
        end else if ((state == ISSUE) || (state == WAIT)) begin
            wait_count <= wait_count + 32'h1;
        end
    end

    // The budget runs out on the cycle whose increment would reach TIMEOUT_CYCLES.
    assign timeout_hit = (wait_count >= 32'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // State register; an asserted reset drops any transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs. The enable follows memory_ready only
    // while in ISSUE, and ISSUE is left on the same edge, so it pulses once.
    // An accepted enable takes priority over a timeout landing on that cycle.
    always_comb begin
        state_next    = state;
        req_ready     = 1'b0;
        memory_enable = 1'b0;
        resp_valid    = 1'b0;
        timeout_fire  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = req_misaligned ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                memory_enable = memory_ready;
                if (memory_ready) begin
                    state_next = WAIT;
                end else if (timeout_hit) begin
                    state_next   = RESP;
                    timeout_fire = 1'b1;
                end
            end
            WAIT: begin
                if (memory_valid) begin
                    state_next = RESP;
                end else if (timeout_hit) begin
                    state_next   = RESP;
                    timeout_fire = 1'b1;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latch, load-data capture and fault flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_reg       <= 32'h0;
            size_reg       <= 2'd0;
            unsigned_reg   <= 1'b0;
            write_reg      <= 1'b0;
            wdata_reg      <= 32'h0;
            mask_reg       <= 32'h0;
            rdata_reg      <= 32'h0;
            misaligned_reg <= 1'b0;
            timeout_reg    <= 1'b0;
        end else if (accept) begin
            addr_reg       <= req_address;
            size_reg       <= req_size;
            unsigned_reg   <= req_unsigned;
            write_reg      <= req_write;
            // reads, and stores that will never be issued, present zero data/mask
            wdata_reg      <= (req_write && !req_misaligned) ? store_data : 32'h0;
            mask_reg       <= (req_write && !req_misaligned) ? store_mask : 32'h0;
            rdata_reg      <= 32'h0;
            misaligned_reg <= req_misaligned;
            timeout_reg    <= 1'b0;
        end else if ((state == WAIT) && memory_valid) begin
            rdata_reg      <= write_reg ? 32'h0 : load_data;
        end else if (timeout_fire) begin
            timeout_reg    <= 1'b1;
        end
    end

    assign read_memory_address  = addr_reg;
    assign write_memory_address = addr_reg;
    assign write_memory_data    = wdata_reg;
    assign write_memory_mask    = mask_reg;
    assign memory_command       = write_reg ? controller_pkg::WRITE : controller_pkg::READ;

    assign resp_rdata      = rdata_reg;
    assign resp_misaligned = resp_valid && misaligned_reg;
    assign resp_timeout    = resp_valid && timeout_reg;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
//==============================================================================
// Module      : tb_load_store_unit
// Description : Directed self-checking bench for load_store_unit with an
//               inline single-word-granular memory responder.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_address = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic        resp_timeout;
    logic        memory_ready = 1'b0;
    logic        memory_valid = 1'b0;
    logic [31:0] read_memory_data = 32'h0;
    logic [31:0] read_memory_address;
    logic [31:0] write_memory_address;
    logic [31:0] write_memory_data;
    logic [31:0] write_memory_mask;
    logic        memory_command;
    logic        memory_enable;

    load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
        .clk                  (clk),
        .reset                (reset),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_write            (req_write),
        .req_size             (req_size),
        .req_unsigned         (req_unsigned),
        .req_address          (req_address),
        .req_wdata            (req_wdata),
        .resp_valid           (resp_valid),
        .resp_rdata           (resp_rdata),
        .resp_misaligned      (resp_misaligned),
        .resp_timeout         (resp_timeout),
        .memory_ready         (memory_ready),
        .memory_valid         (memory_valid),
        .read_memory_data     (read_memory_data),
        .read_memory_address  (read_memory_address),
        .write_memory_address (write_memory_address),
        .write_memory_data    (write_memory_data),
        .write_memory_mask    (write_memory_mask),
        .memory_command       (memory_command),
        .memory_enable        (memory_enable)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [logic [29:0]];

    // results of the most recent transaction
    int          lat;
    int          en_cnt;
    logic [31:0] got_rdata, got_wdata, got_mask, got_raddr, got_waddr;
    logic        got_cmd, got_mis, got_tout;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One request; acceptance edge is E0, cycle c is the negedge inside E(c-1)->E(c).
    // memory_ready stays low for rdy_delay cycles; memory_valid comes vld_delay
    // cycles after the best-case slot following the enable.
    task automatic txn(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int rdy_delay, input int vld_delay);
        int          valid_at;
        logic [31:0] rd_word;
        logic [29:0] key;
        valid_at  = -1;
        rd_word   = 32'h0;
        lat       = -1;
        en_cnt    = 0;
        got_rdata = 32'h0; got_wdata = 32'h0; got_mask = 32'h0;
        got_raddr = 32'h0; got_waddr = 32'h0;
        got_cmd   = 1'b0;  got_mis = 1'b0; got_tout = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_address = addr; req_wdata = wd;
        memory_ready = 1'b0; memory_valid = 1'b0;
        #1;
        chk("req_ready_idle", {31'h0, req_ready}, 32'h1);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            req_valid        = 1'b0;
            memory_ready     = (c > rdy_delay);
            memory_valid     = (c == valid_at);
            read_memory_data = memory_valid ? rd_word : 32'h0;
            #1;
            if (memory_enable) begin
                en_cnt++;
                got_cmd   = memory_command;
                got_wdata = write_memory_data;
                got_mask  = write_memory_mask;
                got_raddr = read_memory_address;
                got_waddr = write_memory_address;
                key       = read_memory_address[31:2];
                if (!mem.exists(key)) mem[key] = 32'h0;
                if (memory_command == controller_pkg::WRITE)
                    mem[key] = (mem[key] & ~write_memory_mask) | (write_memory_data & write_memory_mask);
                rd_word  = mem[key];
                valid_at = c + 1 + vld_delay;
            end
            if (resp_valid) begin
                lat       = c;
                got_rdata = resp_rdata;
                got_mis   = resp_misaligned;
                got_tout  = resp_timeout;
                break;
            end
        end
        memory_ready = 1'b0; memory_valid = 1'b0; read_memory_data = 32'h0;
    endtask

    initial begin
        // ---- reset state ----
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready",  {31'h0, req_ready},       32'h1);
        chk("rst_enable",     {31'h0, memory_enable},   32'h0);
        chk("rst_resp_valid", {31'h0, resp_valid},      32'h0);
        chk("rst_misaligned", {31'h0, resp_misaligned}, 32'h0);
        chk("rst_timeout",    {31'h0, resp_timeout},    32'h0);
        chk("rst_rdata",      resp_rdata,               32'h0);
        chk("rst_raddr",      read_memory_address,      32'h0);
        chk("rst_waddr",      write_memory_address,     32'h0);
        chk("rst_wdata",      write_memory_data,        32'h0);
        chk("rst_mask",       write_memory_mask,        32'h0);
        @(negedge clk);
        reset = 1'b1;

        // ---- SW 0xDEADBEEF @ 0x80000010 ----
        txn(1'b1, 2'd2, 1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 0, 0);
        chk("sw_lat",   lat,    32'd3);
        chk("sw_en",    en_cnt, 32'd1);
        chk("sw_cmd",   {31'h0, got_cmd}, 32'h1);
        chk("sw_data",  got_wdata, 32'hDEAD_BEEF);
        chk("sw_mask",  got_mask,  32'hFFFF_FFFF);
        chk("sw_waddr", got_waddr, 32'h8000_0010);
        chk("sw_raddr", got_raddr, 32'h8000_0010);
        chk("sw_rdata", got_rdata, 32'h0);
        chk("sw_tout",  {31'h0, got_tout}, 32'h0);

        // ---- LW back ----
        txn(1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'h0, 0, 0);
        chk("lw_lat",   lat,    32'd3);
        chk("lw_en",    en_cnt, 32'd1);
        chk("lw_cmd",   {31'h0, got_cmd}, 32'h0);
        chk("lw_rdata", got_rdata, 32'hDEAD_BEEF);
        chk("lw_wdata", got_wdata, 32'h0);
        chk("lw_mask",  got_mask,  32'h0);

        // ---- SB 0x80 @ 0x80000013 ----
        txn(1'b1, 2'd0, 1'b0, 32'h8000_0013, 32'h1234_5680, 0, 0);
        chk("sb_data", got_wdata, 32'h8080_8080);
        chk("sb_mask", got_mask,  32'hFF00_0000);
        chk("sb_lat",  lat,       32'd3);

        // ---- LB / LBU from 0x80000013 (word is now 0x80ADBEEF) ----
        txn(1'b0, 2'd0, 1'b0, 32'h8000_0013, 32'h0, 0, 0);
        chk("lb_rdata", got_rdata, 32'hFFFF_FF80);
        txn(1'b0, 2'd0, 1'b1, 32'h8000_0013, 32'h0, 0, 0);
        chk("lbu_rdata", got_rdata, 32'h0000_0080);

        // ---- misaligned LH @ 0x80000001 ----
        txn(1'b0, 2'd1, 1'b0, 32'h8000_0001, 32'h0, 0, 0);
        chk("lh_mis_lat",   lat,    32'd1);
        chk("lh_mis_flag",  {31'h0, got_mis}, 32'h1);
        chk("lh_mis_en",    en_cnt, 32'd0);
        chk("lh_mis_rdata", got_rdata, 32'h0);

        // ---- LW with memory_ready low for 4 cycles ----
        txn(1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'h0, 4, 0);
        chk("lw_stall_lat",   lat,    32'd7);
        chk("lw_stall_en",    en_cnt, 32'd1);
        chk("lw_stall_rdata", got_rdata, 32'h80AD_BEEF);

        // ---- SH 0xCAFE @ 0x80000012 ----
        txn(1'b1, 2'd1, 1'b0, 32'h8000_0012, 32'h1234_CAFE, 0, 0);
        chk("sh_data", got_wdata, 32'hCAFE_CAFE);
        chk("sh_mask", got_mask,  32'hFFFF_0000);

        // ---- halfword / byte loads from 0xCAFEBEEF ----
        txn(1'b0, 2'd1, 1'b0, 32'h8000_0012, 32'h0, 0, 0);
        chk("lh_rdata", got_rdata, 32'hFFFF_CAFE);
        txn(1'b0, 2'd1, 1'b1, 32'h8000_0012, 32'h0, 0, 0);
        chk("lhu_rdata", got_rdata, 32'h0000_CAFE);
        txn(1'b0, 2'd0, 1'b0, 32'h8000_0011, 32'h0, 0, 0);
        chk("lb1_rdata", got_rdata, 32'hFFFF_FFBE);

        // ---- misaligned SW @ 0x80000012 ----
        txn(1'b1, 2'd2, 1'b0, 32'h8000_0012, 32'h5555_5555, 0, 0);
        chk("sw_mis_flag", {31'h0, got_mis}, 32'h1);
        chk("sw_mis_lat",  lat,    32'd1);
        chk("sw_mis_en",   en_cnt, 32'd0);

        // ---- size 3 load with two extra WAIT cycles ----
        txn(1'b0, 2'd3, 1'b0, 32'h8000_0010, 32'h0, 0, 2);
        chk("l3_lat",   lat,       32'd5);
        chk("l3_rdata", got_rdata, 32'hCAFE_BEEF);

        // ---- stray memory_valid while idle ----
        @(negedge clk);
        memory_valid = 1'b1; read_memory_data = 32'hFFFF_FFFF;
        #1;
        chk("stray_resp", {31'h0, resp_valid}, 32'h0);
        @(negedge clk);
        memory_valid = 1'b0; read_memory_data = 32'h0;
        #1;
        chk("stray_resp2", {31'h0, resp_valid}, 32'h0);
        chk("stray_ready", {31'h0, req_ready},  32'h1);
        txn(1'b0, 2'd0, 1'b1, 32'h8000_0010, 32'h0, 0, 0);
        chk("post_stray_lat",   lat,       32'd3);
        chk("post_stray_rdata", got_rdata, 32'h0000_00EF);

        // ---- reset asserted while in WAIT ----
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_address = 32'h8000_0010;
        memory_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0; memory_ready = 1'b1;
        #1;
        chk("rw_enable_issue", {31'h0, memory_enable}, 32'h1);
        @(negedge clk);
        memory_ready = 1'b1;
        #1;
        chk("rw_enable_wait", {31'h0, memory_enable}, 32'h0);
        reset = 1'b0;
        #1;
        chk("rw_enable",     {31'h0, memory_enable}, 32'h0);
        chk("rw_resp_valid", {31'h0, resp_valid},    32'h0);
        chk("rw_req_ready",  {31'h0, req_ready},     32'h1);
        @(negedge clk);
        memory_ready = 1'b0;
        reset = 1'b1;
        txn(1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'h0, 0, 0);
        chk("post_rst_lat",   lat,       32'd3);
        chk("post_rst_rdata", got_rdata, 32'hCAFE_BEEF);

`ifdef LSU_TIMEOUT_EN
        // ---- timeout: memory_valid never comes ----
        txn(1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'h0, 0, 1000);
        chk("to_flag",  {31'h0, got_tout}, 32'h1);
        chk("to_rdata", got_rdata, 32'h0);
        chk("to_en",    en_cnt,    32'd1);
        @(negedge clk);
        memory_valid = 1'b1; read_memory_data = 32'h1111_1111;
        #1;
        chk("to_stray_resp", {31'h0, resp_valid}, 32'h0);
        @(negedge clk);
        memory_valid = 1'b0; read_memory_data = 32'h0;
        txn(1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'h0, 0, 0);
        chk("to_next_lat",   lat,       32'd3);
        chk("to_next_rdata", got_rdata, 32'hCAFE_BEEF);
        chk("to_next_flag",  {31'h0, got_tout}, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
